// File: rtl/rf_stage_pipe_if.sv
// rf_stage_pipe bus bundle: decode-side input, writeback port,
// forwarding sources and the registered EX-side output.
interface rf_stage_pipe_if #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [ADDR_W-1:0]         rn;
  logic [ADDR_W-1:0]         rm;
  logic [ADDR_W-1:0]         rd;
  logic                      reg2loc;
  logic                      alu_src;
  logic                      imm_sel;
  logic [11:0]               alu_imm;
  logic [8:0]                ld_sr_imm;
  logic                      wb_we;
  logic [ADDR_W-1:0]         wb_addr;
  logic [DATA_W-1:0]         wb_data;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD-1:0]        fwd_pending;
  logic [NUM_FWD*ADDR_W-1:0] fwd_addr;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         data_a;
  logic [DATA_W-1:0]         data_b;
  logic [DATA_W-1:0]         store_data;
  logic [ADDR_W-1:0]         out_rd;

  modport slave (
    input  in_valid, rn, rm, rd,
    input  reg2loc, alu_src, imm_sel,
    input  alu_imm, ld_sr_imm,
    input  wb_we, wb_addr, wb_data,
    input  fwd_valid, fwd_pending,
    input  fwd_addr, fwd_data,
    input  flush, out_ready,
    output in_ready, out_valid,
    output data_a, data_b,
    output store_data, out_rd
  );

  modport master (
    output in_valid, rn, rm, rd,
    output reg2loc, alu_src, imm_sel,
    output alu_imm, ld_sr_imm,
    output wb_we, wb_addr, wb_data,
    output fwd_valid, fwd_pending,
    output fwd_addr, fwd_data,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  data_a, data_b,
    input  store_data, out_rd
  );
endinterface

// File: rtl/rf_stage_pipe.sv
// Register-read stage: register file, forwarding/bypass
// operand resolution, immediate select, ID/EX register.
module rf_stage_pipe #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ZERO_REG = 31
) (
  input logic         clk,
  input logic         rst_n,
  rf_stage_pipe_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              pend;
  } opnd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] store_data;
    logic [ADDR_W-1:0] rd;
  } id_ex_t;

  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] addr_b;
  opnd_t             op_a;
  opnd_t             op_b;
  logic [DATA_W-1:0] imm;
  logic              hazard;
  logic              ready;
  logic              capture;
  logic              drain;
  logic              out_valid_q;
  id_ex_t            ex_q;
  id_ex_t            ex_d;

  // XZR first, then youngest forward, then writeback, then file.
  function automatic opnd_t resolve(
    input logic [ADDR_W-1:0]         a,
    input logic [NUM_FWD-1:0]        fv,
    input logic [NUM_FWD-1:0]        fp,
    input logic [NUM_FWD*ADDR_W-1:0] fa,
    input logic [NUM_FWD*DATA_W-1:0] fd,
    input logic                      we,
    input logic [ADDR_W-1:0]         wa,
    input logic [DATA_W-1:0]         wd,
    input logic [DATA_W-1:0]         rv
  );
    opnd_t r;
    logic  hit;
    r.data = rv;
    r.pend = 1'b0;
    hit    = 1'b0;
    if (a == ZR) begin
      r.data = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && fv[i] &&
            fa[i*ADDR_W +: ADDR_W] == a) begin
          hit    = 1'b1;
          r.data = fd[i*DATA_W +: DATA_W];
          r.pend = fp[i];
        end
      end
      if (!hit && we && wa == a)
        r.data = wd;
    end
    return r;
  endfunction

  // Operand resolution for both read ports.
  always_comb begin
    addr_b = bus.reg2loc ? bus.rm : bus.rd;
    op_a = resolve(bus.rn, bus.fwd_valid,
                   bus.fwd_pending, bus.fwd_addr,
                   bus.fwd_data, bus.wb_we,
                   bus.wb_addr, bus.wb_data,
                   regs[bus.rn]);
    op_b = resolve(addr_b, bus.fwd_valid,
                   bus.fwd_pending, bus.fwd_addr,
                   bus.fwd_data, bus.wb_we,
                   bus.wb_addr, bus.wb_data,
                   regs[addr_b]);
  end

  // Immediate select and next ID/EX bundle.
  always_comb begin
    if (bus.imm_sel)
      imm = {{(DATA_W-9){bus.ld_sr_imm[8]}},
             bus.ld_sr_imm};
    else
      imm = {{(DATA_W-12){1'b0}}, bus.alu_imm};
    ex_d.data_a     = op_a.data;
    ex_d.data_b     = bus.alu_src ? imm : op_b.data;
    ex_d.store_data = op_b.data;
    ex_d.rd         = bus.rd;
  end

  // Handshake: hazard stalls, flush always drains the input.
  always_comb begin
    hazard  = bus.in_valid && (op_a.pend || op_b.pend);
    drain   = bus.out_ready || !out_valid_q;
    ready   = bus.flush || (!hazard && drain);
    capture = bus.in_valid && ready && !bus.flush;
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.data_a     = ex_q.data_a;
  assign bus.data_b     = ex_q.data_b;
  assign bus.store_data = ex_q.store_data;
  assign bus.out_rd     = ex_q.rd;

  // Register file; XZR writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (bus.wb_we && bus.wb_addr != ZR) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ID/EX register: flush, capture, bubble, else stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ex_q        <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      ex_q        <= ex_d;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
